// File: rtl/sdram_port_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the SDRAM controller.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface sdram_port_arbiter_if #(
    parameter int ADDR_WIDTH = 25,
    parameter int DATA_WIDTH = 16
);
    logic                  p0_valid;
    logic                  p0_we;
    logic [ADDR_WIDTH-1:0] p0_addr;
    logic [DATA_WIDTH-1:0] p0_wdata;
    logic                  p0_ready;
    logic [DATA_WIDTH-1:0] p0_rdata;
    logic                  p0_rvalid;

    logic                  p1_valid;
    logic                  p1_we;
    logic [ADDR_WIDTH-1:0] p1_addr;
    logic [DATA_WIDTH-1:0] p1_wdata;
    logic                  p1_ready;
    logic [DATA_WIDTH-1:0] p1_rdata;
    logic                  p1_rvalid;

    logic [ADDR_WIDTH-1:0] m_axi_awaddr;
    logic                  m_axi_awvalid;
    logic                  m_axi_awready;
    logic [DATA_WIDTH-1:0] m_axi_wdata;
    logic                  m_axi_wvalid;
    logic                  m_axi_wready;
    logic [ADDR_WIDTH-1:0] m_axi_araddr;
    logic                  m_axi_arvalid;
    logic                  m_axi_arready;
    logic [DATA_WIDTH-1:0] m_axi_rdata;
    logic                  m_axi_rvalid;
    logic                  m_axi_rready;

    logic                  ref_req;
    logic                  ref_ack;

    modport slave (
        input  p0_valid, p0_we, p0_addr, p0_wdata,
        output p0_ready, p0_rdata, p0_rvalid,
        input  p1_valid, p1_we, p1_addr, p1_wdata,
        output p1_ready, p1_rdata, p1_rvalid,
        output m_axi_awaddr, m_axi_awvalid,
        input  m_axi_awready,
        output m_axi_wdata, m_axi_wvalid,
        input  m_axi_wready,
        output m_axi_araddr, m_axi_arvalid,
        input  m_axi_arready,
        input  m_axi_rdata, m_axi_rvalid,
        output m_axi_rready,
        output ref_req,
        input  ref_ack
    );

    modport master (
        output p0_valid, p0_we, p0_addr, p0_wdata,
        input  p0_ready, p0_rdata, p0_rvalid,
        output p1_valid, p1_we, p1_addr, p1_wdata,
        input  p1_ready, p1_rdata, p1_rvalid,
        input  m_axi_awaddr, m_axi_awvalid,
        output m_axi_awready,
        input  m_axi_wdata, m_axi_wvalid,
        output m_axi_wready,
        input  m_axi_araddr, m_axi_arvalid,
        output m_axi_arready,
        output m_axi_rdata, m_axi_rvalid,
        input  m_axi_rready,
        input  ref_req,
        output ref_ack
    );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Two-port round-robin arbiter in front of an SDRAM controller, one operation
// in flight at a time, with a free-running refresh timer that wins at IDLE.
//
// state   | meaning
// IDLE    | waiting; refresh due beats any requester, else round-robin grant
// WR      | write address and data offered, each dropped once accepted
// RD_ADDR | read address offered until accepted
// RD_DATA | waiting for read data, routed to the owning port
// REFRESH | ref_req held until the controller acknowledges
module sdram_port_arbiter #(
    parameter int ADDR_WIDTH     = 25,
    parameter int DATA_WIDTH     = 16,
    parameter int REFRESH_CYCLES = 780
) (
    input  logic               clk,
    input  logic               reset,
    sdram_port_arbiter_if.slave bus
);
    localparam int CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(REFRESH_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, WR, RD_ADDR, RD_DATA, REFRESH} state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_last_grant;
    logic                  r_port;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_aw_done;
    logic                  r_w_done;
    logic                  r_refresh_pending;
    logic [CNT_W-1:0]      r_ref_cnt;
    logic [DATA_WIDTH-1:0] r_p0_rdata;
    logic [DATA_WIDTH-1:0] r_p1_rdata;
    logic                  r_p0_rvalid;
    logic                  r_p1_rvalid;

    logic w_expire;
    logic w_refresh_due;
    logic w_grant;
    logic w_grant_id;
    logic w_aw_hs;
    logic w_w_hs;
    logic w_wr_done;
    logic w_rd_done;

    assign w_expire      = (r_ref_cnt == '0);
    // An expiry this very cycle counts as pending so the refresh starts without a lost cycle
    assign w_refresh_due = r_refresh_pending | w_expire;
    assign w_aw_hs       = (r_state == WR) & ~r_aw_done & bus.m_axi_awready;
    assign w_w_hs        = (r_state == WR) & ~r_w_done & bus.m_axi_wready;
    assign w_wr_done     = (r_aw_done | w_aw_hs) & (r_w_done | w_w_hs);
    assign w_rd_done     = (r_state == RD_DATA) & bus.m_axi_rvalid;

    always_comb begin
        w_next     = r_state;
        w_grant    = 1'b0;
        w_grant_id = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_refresh_due) begin
                    w_next = REFRESH;
                end else if (bus.p0_valid | bus.p1_valid) begin
                    w_grant    = 1'b1;
                    w_grant_id = (bus.p0_valid & bus.p1_valid) ? ~r_last_grant : bus.p1_valid;
                    if (w_grant_id ? bus.p1_we : bus.p0_we)
                        w_next = WR;
                    else
                        w_next = RD_ADDR;
                end
            end
            WR:      if (w_wr_done)          w_next = IDLE;
            RD_ADDR: if (bus.m_axi_arready)  w_next = RD_DATA;
            RD_DATA: if (bus.m_axi_rvalid)   w_next = IDLE;
            REFRESH: if (bus.ref_ack)        w_next = IDLE;
            default:                         w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_grant      <= 1'b1;
            r_port            <= 1'b0;
            r_we              <= 1'b0;
            r_addr            <= '0;
            r_wdata           <= '0;
            r_aw_done         <= 1'b0;
            r_w_done          <= 1'b0;
            r_refresh_pending <= 1'b0;
            r_ref_cnt         <= CNT_RELOAD;
            r_p0_rdata        <= '0;
            r_p1_rdata        <= '0;
            r_p0_rvalid       <= 1'b0;
            r_p1_rvalid       <= 1'b0;
        end else begin
            r_p0_rvalid <= 1'b0;
            r_p1_rvalid <= 1'b0;
            if (w_grant) begin
                r_port       <= w_grant_id;
                r_last_grant <= w_grant_id;
                r_we         <= w_grant_id ? bus.p1_we    : bus.p0_we;
                r_addr       <= w_grant_id ? bus.p1_addr  : bus.p0_addr;
                r_wdata      <= w_grant_id ? bus.p1_wdata : bus.p0_wdata;
                r_aw_done    <= 1'b0;
                r_w_done     <= 1'b0;
            end
            if (w_aw_hs) r_aw_done <= 1'b1;
            if (w_w_hs)  r_w_done  <= 1'b1;
            if (w_rd_done) begin
                if (r_port) begin
                    r_p1_rdata  <= bus.m_axi_rdata;
                    r_p1_rvalid <= 1'b1;
                end else begin
                    r_p0_rdata  <= bus.m_axi_rdata;
                    r_p0_rvalid <= 1'b1;
                end
            end
            if (w_expire)
                r_ref_cnt <= CNT_RELOAD;
            else
                r_ref_cnt <= r_ref_cnt - 1'b1;
            // Expiry wins over an acknowledge in the same cycle so that refresh is not lost
            if (w_expire)
                r_refresh_pending <= 1'b1;
            else if ((r_state == REFRESH) && bus.ref_ack)
                r_refresh_pending <= 1'b0;
        end
    end

    assign bus.p0_ready      = w_grant & ~w_grant_id & ~reset;
    assign bus.p1_ready      = w_grant &  w_grant_id & ~reset;
    assign bus.p0_rdata      = r_p0_rdata;
    assign bus.p1_rdata      = r_p1_rdata;
    assign bus.p0_rvalid     = r_p0_rvalid;
    assign bus.p1_rvalid     = r_p1_rvalid;
    assign bus.m_axi_awaddr  = r_we ? r_addr : '0;
    assign bus.m_axi_awvalid = (r_state == WR) & ~r_aw_done;
    assign bus.m_axi_wdata   = r_wdata;
    assign bus.m_axi_wvalid  = (r_state == WR) & ~r_w_done;
    assign bus.m_axi_araddr  = r_we ? '0 : r_addr;
    assign bus.m_axi_arvalid = (r_state == RD_ADDR);
    assign bus.m_axi_rready  = (r_state == RD_DATA);
    assign bus.ref_req       = (r_state == REFRESH);
endmodule
